// File: rtl/bin_to_bcd_module_if.sv
// Request/result bundle between a binary producer and the BCD converter.
// The master drives a value and a start request; the slave returns digits.
interface bin_to_bcd_module_if #(
    parameter int BIN_W = 20
);
    logic [BIN_W-1:0] bin_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [23:0]      number_sig;
    logic             ovf;

    modport master (
        output bin_in,
        output start,
        input  busy,
        input  done,
        input  number_sig,
        input  ovf
    );

    modport slave (
        input  bin_in,
        input  start,
        output busy,
        output done,
        output number_sig,
        output ovf
    );
endinterface

// File: rtl/bin_to_bcd_module.sv
// Sequential shift-and-add-3 binary to six-digit packed BCD converter.
// Results are published only in DONE so the display never sees partial digits.
module bin_to_bcd_module #(
    parameter int          BIN_W   = 20,
    parameter int unsigned MAX_VAL = 999999
) (
    input  logic               CLK,
    input  logic               RST,
    bin_to_bcd_module_if.slave bus
);
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [23:0]      bcd_q, bcd_d;
    logic [23:0]      bcd_adj;
    logic [23:0]      num_q, num_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovfn_q, ovfn_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             over;

    assign over = 32'(bus.bin_in) > MAX_VAL;

    // Independent per-nibble correction, no carry between digits.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        ovfn_d  = ovfn_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (bus.start) begin
                    bin_d   = over ? BIN_W'(MAX_VAL) : bus.bin_in;
                    ovfn_d  = over;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[22:0], bin_q[BIN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1))
                    state_d = DONE;
            end
            DONE: begin
                num_d   = bcd_q;
                ovf_d   = ovfn_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            ovfn_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            ovfn_q  <= ovfn_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.number_sig = num_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_module.sv
// Scoreboard bench for the binary to BCD converter.
// Expected digits come from a decimal division model, not from double dabble.
module tb_bin_to_bcd_module;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    logic [24:0] q[$];

    bin_to_bcd_module_if #(.BIN_W(20)) bus ();

    bin_to_bcd_module #(
        .BIN_W  (20),
        .MAX_VAL(999999)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) if (bus.done === 1'b1) done_cnt++;

    function automatic logic [24:0] model(input logic [19:0] v);
        int unsigned s;
        logic [23:0] r;
        s = (v > 20'd999999) ? 999999 : 32'(v);
        r = '0;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return {v > 20'd999999, r};
    endfunction

    task automatic wait_done(output int lat, output bit held);
        logic [23:0] prev;
        prev = bus.number_sig;
        lat  = -1;
        held = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
            if (bus.number_sig !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.start = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.ovf});
        end
        checks++;
        if (bus.number_sig !== 24'h000000) begin
            errors++;
            $display("FAIL reset_number: got %h required 000000", bus.number_sig);
        end
    endtask

    task automatic test_conversion(input logic [19:0] v);
        int lat;
        bit held;
        logic [24:0] exp;
        q.push_back(model(v));
        bus.bin_in = v;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.bin_in = ~v;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start(%0d): got %b required 1", v, bus.busy);
        end
        wait_done(lat, held);
        exp = q.pop_front();
        checks++;
        if (lat != 21) begin
            errors++;
            $display("FAIL latency(%0d): got %0d required 21", v, lat);
        end
        checks++;
        if (bus.number_sig !== exp[23:0]) begin
            errors++;
            $display("FAIL number(%0d): got %h required %h", v, bus.number_sig, exp[23:0]);
        end
        checks++;
        if (bus.ovf !== exp[24]) begin
            errors++;
            $display("FAIL ovf(%0d): got %b required %b", v, bus.ovf, exp[24]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done(%0d): got %b required 0", v, bus.busy);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL hold(%0d): got changed required stable", v);
        end
        @(negedge CLK);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_width(%0d): got %b required 0", v, bus.done);
        end
    endtask

    task automatic test_basic();
        test_conversion(20'd123456);
    endtask

    task automatic test_values();
        test_conversion(20'd0);
        test_conversion(20'd999999);
        test_conversion(20'd9);
        test_conversion(20'd10);
    endtask

    task automatic test_saturation();
        test_conversion(20'hFFFFF);
        test_conversion(20'd1000000);
        test_conversion(20'd42);
    endtask

    task automatic test_ignore_start();
        logic [23:0] prev;
        logic [24:0] exp;
        int ndone;
        int d0;
        bit held;
        prev = bus.number_sig;
        held = 1'b1;
        ndone = 0;
        q.push_back(model(20'd500));
        bus.bin_in = 20'd500;
        bus.start = 1'b1;
        d0 = done_cnt;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            bus.start = (i == 5 || i == 10);
            if (i >= 5) bus.bin_in = 20'd777;
            if (bus.done === 1'b1) begin
                ndone++;
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    checks++;
                    if (bus.number_sig !== exp[23:0]) begin
                        errors++;
                        $display("FAIL ignore_number: got %h required %h", bus.number_sig, exp[23:0]);
                    end
                end
            end else if (ndone == 0 && bus.number_sig !== prev) begin
                held = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d/%0d required 1", ndone, done_cnt - d0);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL ignore_hold: got changed required %h", prev);
        end
        q.delete();
    endtask

    task automatic test_reset_abort();
        int d0;
        bus.bin_in = 20'd654321;
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (9) @(negedge CLK);
        d0 = done_cnt;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b required 0", bus.busy);
        end
        checks++;
        if (bus.number_sig !== 24'h000000) begin
            errors++;
            $display("FAIL abort_number: got %h required 000000", bus.number_sig);
        end
        repeat (30) @(negedge CLK);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses required 0", done_cnt - d0);
        end
        test_conversion(20'd31);
    endtask

    task automatic test_back_to_back();
        logic [23:0] prev;
        logic [24:0] exp;
        int k;
        int last;
        int d0;
        q.push_back(model(20'd1));
        q.push_back(model(20'd2));
        q.push_back(model(20'd3));
        prev = bus.number_sig;
        k = 0;
        last = 0;
        d0 = done_cnt;
        bus.bin_in = 20'd1;
        bus.start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                exp = q.pop_front();
                checks++;
                if (bus.number_sig !== exp[23:0]) begin
                    errors++;
                    $display("FAIL b2b_number%0d: got %h required %h", k, bus.number_sig, exp[23:0]);
                end
                checks++;
                if (i - last != 22) begin
                    errors++;
                    $display("FAIL b2b_period%0d: got %0d required 22", k, i - last);
                end
                last = i;
                k++;
                prev = bus.number_sig;
                if (k == 3) begin
                    bus.start = 1'b0;
                    break;
                end
                bus.bin_in = 20'(k + 1);
            end else if (bus.number_sig !== prev) begin
                checks++;
                errors++;
                $display("FAIL b2b_glitch: got %h required %h", bus.number_sig, prev);
                prev = bus.number_sig;
            end
        end
        bus.start = 1'b0;
        repeat (30) @(negedge CLK);
        checks++;
        if (k != 3 || done_cnt - d0 != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d/%0d required 3", k, done_cnt - d0);
        end
        q.delete();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bin_in = '0;
        test_reset();
        test_basic();
        test_values();
        test_saturation();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_module.md
Name: bin_to_bcd_module

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Takes a binary value (e.g. a count or an EEPROM readback), converts it to six packed BCD digits, and presents them on a 24-bit bus.
- Sits directly upstream of the 6-digit scan controller, which consumes number_sig nibble by nibble ([23:20] most significant digit).
- The output is held stable between conversions, so the display never shows a partial result.

Parameters:
- BIN_W, 20, width of the binary input; legal range 4..20.
- MAX_VAL, 999999, saturation limit; the largest value six BCD digits can show.

Ports:
- CLK  input  1  system clock (50 MHz).
- RST  input  1  synchronous reset, active-high.
- bin_in  input  BIN_W  binary value to convert; sampled only when start is accepted.
- start  input  1  conversion request; level-sampled each CLK edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when number_sig and ovf have just updated.
- number_sig  output  24  six packed BCD digits; [23:20] = 10^5 digit, [3:0] = 10^0 digit.
- ovf  output  1  high when the last converted input exceeded MAX_VAL.

Behaviour:
- Reset: when RST=1 at a CLK edge:
  - state <= IDLE; busy, done, ovf <= 0; number_sig <= 24'h000000.
  - Internal shift register and iteration counter are cleared.
  - Any conversion in progress is aborted; no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - done <= 0.
  - If start=1: load bin_reg with min(bin_in, MAX_VAL), load ovf_next with (bin_in > MAX_VAL), clear the 24-bit BCD accumulator, clear iteration counter cnt, busy <= 1, go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT (exactly BIN_W cycles), each cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {bcd, bin_reg} left by one bit.
  - cnt <= cnt + 1.
  - On the cycle where cnt == BIN_W-1, go to DONE.
- DONE (one cycle):
  - number_sig <= bcd; ovf <= ovf_next; done <= 1; busy <= 0; go to IDLE.
- Latency:
  - start sampled at edge N; busy high after edge N.
  - number_sig, ovf and done valid after edge N+BIN_W+1 (21 cycles at the default).
  - done is high for exactly one cycle.
- start while busy (SHIFT or DONE) is ignored and not queued.
- bin_in changes after start is accepted do not affect the running conversion.
- Back-to-back: start held high gives one conversion every BIN_W+2 cycles (the IDLE cycle accepts the next request).
- number_sig and ovf change only in DONE (and on reset). They are stable at all other times.
- Arithmetic:
  - Add-3 is per nibble, 4-bit, with no carry between nibbles.
  - The BCD accumulator is 24 bits. Saturation guarantees it never exceeds 6 digits.
- Saturation: inputs above MAX_VAL convert as MAX_VAL (24'h999999) with ovf=1. An input exactly equal to MAX_VAL gives ovf=0.
- For BIN_W < 20 no input can exceed MAX_VAL, so ovf stays 0.

Test Plan:
- Reset, then start with bin_in=123456 for 1 cycle -> busy=1 the next cycle; after 21 cycles done=1 for exactly 1 cycle, number_sig=24'h123456, ovf=0, busy=0.
- bin_in=0, then bin_in=999999 -> number_sig=24'h000000, then 24'h999999; ovf=0 both times. Check 9 -> 24'h000009 and 10 -> 24'h000010 across the digit boundary.
- bin_in=20'hFFFFF (1048575), then 1000000 -> number_sig=24'h999999, ovf=1 both; a following 42 -> 24'h000042, ovf=0.
- Start a conversion of 500; change bin_in to 777 and pulse start at cycles 5 and 10 -> exactly one done, number_sig=24'h000500. number_sig holds its previous value until that done.
- Convert 654321; assert RST at cycle 10 -> busy=0, done never pulses, number_sig=24'h000000. The next start with 31 -> 24'h000031 after 21 cycles.
- Hold start high with bin_in stepping 1, 2, 3 -> done pulses every 22 cycles; number_sig updates 24'h000001, 24'h000002, 24'h000003 with no intermediate values.
